timer_mux_display: RTL and testbench
====================================

Name: timer_mux_display

Overview:
Parametrised successor to the fixed 6-digit timer. Keeps a BCD hours/minutes/seconds count and drives a multiplexed seven-segment display, one digit per scan slot. Adds a configurable digit count, count-up and countdown modes, start/stop/clear/load controls and an expiry flag. Sits between the board clock/buttons and the seven-segment pins.

Parameters:
DIGITS, 6, number of displayed digits; legal values 2 (SS), 4 (MM:SS), 6 (HH:MM:SS)
TICK_DIV, 50000000, clk cycles per one-second tick; must be at least 2
SCAN_DIV, 50000, clk cycles each digit stays selected; must be at least 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level; sets running
stop  in  1  level; clears running
clear  in  1  level; count to 0, stopped
down  in  1  0 = count up, 1 = count down; sampled at each tick
load  in  1  loads load_h/load_m/load_s, stopped
load_h  in  5  binary hours, 0..23
load_m  in  6  binary minutes, 0..59
load_s  in  6  binary seconds, 0..59
number  out  8  segment pattern for the selected digit, using the shared NUMBER_0..NUMBER_9 codes
digit_block  out  DIGITS  one-hot, active-high digit select; bit 0 = seconds units
expired  out  1  countdown reached 0

Behaviour:
- Reset (async, rst=1):
  - count 00:00:00, running=0, prescaler=0, scan index=0, scan counter=0.
  - digit_block = 1, number = NUMBER_0, expired = 0.
- Internal state, all registered: six BCD nibbles (s0,s1,m0,m1,h0,h1), running, expired, prescaler, scan counter, scan index.
- Outputs decode combinationally from registers only.
- Control priority within one cycle: clear > load > stop > start.
- clear:
  - Count goes to 0, running=0, expired=0, prescaler=0.
- load:
  - Converts each binary field to BCD; an out-of-range field loads 0, other fields load normally.
  - running=0, expired=0, prescaler=0.
  - Fields not displayed for the configured DIGITS are ignored and forced to 0.
- start:
  - Sets running=1; expired=0; prescaler=0 on the stopped-to-running transition only.
  - Has no effect when down=1 and count=0.
- stop: running=0; prescaler holds its value.
- Prescaler:
  - Increments while running; tick is a single-cycle pulse in the cycle where prescaler=TICK_DIV-1, then prescaler wraps to 0.
  - Tick period is exactly TICK_DIV cycles.
- Count update on tick, all nibbles updating in the same cycle:
  - Up, DIGITS=6: wraps 23:59:59 -> 00:00:00.
  - Up, DIGITS=4: wraps 59:59 -> 00:00.
  - Up, DIGITS=2: wraps 59 -> 00.
  - Down: decrements with borrow (10:00 -> 09:59, 01:00:00 -> 00:59:59).
  - Down, tick that makes count 0: running=0 and expired=1 in the same edge. expired holds until clear, load or a successful start.
  - Down, at count 0: no tick occurs, because running is already 0.
- Mode change mid-run: takes effect at the next tick; prescaler is not reset.
- Scan:
  - Scan counter runs continuously, independent of running, and wraps at SCAN_DIV-1.
  - On wrap, scan index advances 0..DIGITS-1 and wraps to 0.
  - digit_block = 1 << scan index.
  - number = segment code of the nibble for that index, in order s0,s1,m0,m1,h0,h1.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset: DIGITS=6, TICK_DIV=4, SCAN_DIV=2; hold rst 3 cycles -> digit_block=000001, number=NUMBER_0, expired=0. Release rst -> digit_block rotates 000001,000010,... changing every 2 cycles and wrapping after 000001 returns in 12 cycles.
- Count-up carry: load 00:00:58, start 1 cycle -> after 8 cycles count=00:01:00; sequence 23:59:59 -> 00:00:00 on the next tick; m0 slot shows NUMBER_1 then NUMBER_0.
- Countdown: down=1, load 00:01:01, start -> ticks every 4 cycles give 00:01:00, 00:00:59, ..., 00:00:00. On the final tick running=0 and expired=1. A later start -> no change. clear -> expired=0.
- Stop/resume: run up, stop with prescaler=2 for 10 cycles -> count frozen. start -> prescaler restarts at 0, next tick 4 cycles later. Assert clear and start together -> count 0, running=0.
- Parametrisation, DIGITS=2 and DIGITS=4: digit_block width 2 / 4. Up wraps 59->00 and 59:59->00:00. load_h=7 is ignored.
- Invalid load and async reset: load_h=25, load_m=61, load_s=30 -> 00:00:30. Pulse rst between clock edges mid-run -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/timer_mux_display.sv
// BCD hours/minutes/seconds timer with up/down counting, load/clear control,
// countdown expiry flag and a time-multiplexed seven-segment digit scan.
module timer_mux_display #(
   parameter int DIGITS   = 6,
   parameter int TICK_DIV = 50000000,
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   input  logic              down,
   input  logic              load,
   input  logic [4:0]        load_h,
   input  logic [5:0]        load_m,
   input  logic [5:0]        load_s,
   output logic [7:0]        number,
   output logic [DIGITS-1:0] digit_block,
   output logic              expired
);

   localparam int PRE_W  = $clog2(TICK_DIV);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = $clog2(DIGITS);

   localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);

   localparam logic [7:0] NUMBER_0 = 8'hC0;
   localparam logic [7:0] NUMBER_1 = 8'hF9;
   localparam logic [7:0] NUMBER_2 = 8'hA4;
   localparam logic [7:0] NUMBER_3 = 8'hB0;
   localparam logic [7:0] NUMBER_4 = 8'h99;
   localparam logic [7:0] NUMBER_5 = 8'h92;
   localparam logic [7:0] NUMBER_6 = 8'h82;
   localparam logic [7:0] NUMBER_7 = 8'hF8;
   localparam logic [7:0] NUMBER_8 = 8'h80;
   localparam logic [7:0] NUMBER_9 = 8'h90;

   logic [3:0]        s0, s1, m0, m1, h0, h1;
   logic [3:0]        u_s0, u_s1, u_m0, u_m1, u_h0, u_h1;
   logic [3:0]        d_s0, d_s1, d_m0, d_m1, d_h0, d_h1;
   logic              running;
   logic [PRE_W-1:0]  prescaler;
   logic [SCAN_W-1:0] scan_cnt;
   logic [IDX_W-1:0]  scan_idx;
   logic              tick, is_zero, dn_zero;
   logic [7:0]        bcd_h, bcd_m, bcd_s;
   logic [3:0]        cur;

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [5:0] t, u;
      t = v / 6'd10;
      u = v % 6'd10;
      return {t[3:0], u[3:0]};
   endfunction

   function automatic logic [7:0] seg(input logic [3:0] d);
      case (d)
         4'd1:    return NUMBER_1;
         4'd2:    return NUMBER_2;
         4'd3:    return NUMBER_3;
         4'd4:    return NUMBER_4;
         4'd5:    return NUMBER_5;
         4'd6:    return NUMBER_6;
         4'd7:    return NUMBER_7;
         4'd8:    return NUMBER_8;
         4'd9:    return NUMBER_9;
         default: return NUMBER_0;
      endcase
   endfunction

   assign tick    = running && (prescaler == PRE_MAX);
   assign is_zero = ({h1, h0, m1, m0, s1, s0} == 24'd0);
   assign dn_zero = ({d_h1, d_h0, d_m1, d_m0, d_s1, d_s0} == 24'd0);

   // Out-of-range or undisplayed fields load as zero.
   always_comb begin
      bcd_s = (load_s < 6'd60) ? to_bcd(load_s) : 8'd0;
      bcd_m = (DIGITS >= 4 && load_m < 6'd60) ? to_bcd(load_m) : 8'd0;
      bcd_h = (DIGITS >= 6 && load_h < 5'd24) ? to_bcd({1'b0, load_h}) : 8'd0;
   end

   // Increment with carry; the carry out of the top displayed field wraps to zero.
   always_comb begin
      {u_h1, u_h0, u_m1, u_m0, u_s1, u_s0} = {h1, h0, m1, m0, s1, s0};
      if (s0 != 4'd9) u_s0 = s0 + 4'd1;
      else begin
         u_s0 = 4'd0;
         if (s1 != 4'd5) u_s1 = s1 + 4'd1;
         else begin
            u_s1 = 4'd0;
            if (DIGITS > 2) begin
               if (m0 != 4'd9) u_m0 = m0 + 4'd1;
               else begin
                  u_m0 = 4'd0;
                  if (m1 != 4'd5) u_m1 = m1 + 4'd1;
                  else begin
                     u_m1 = 4'd0;
                     if (DIGITS > 4) begin
                        if (h1 == 4'd2 && h0 == 4'd3) begin
                           u_h1 = 4'd0;
                           u_h0 = 4'd0;
                        end else if (h0 == 4'd9) begin
                           u_h0 = 4'd0;
                           u_h1 = h1 + 4'd1;
                        end else u_h0 = h0 + 4'd1;
                     end
                  end
               end
            end
         end
      end
   end

   // Decrement with borrow; only used while the count is non-zero.
   always_comb begin
      {d_h1, d_h0, d_m1, d_m0, d_s1, d_s0} = {h1, h0, m1, m0, s1, s0};
      if (s0 != 4'd0) d_s0 = s0 - 4'd1;
      else begin
         d_s0 = 4'd9;
         if (s1 != 4'd0) d_s1 = s1 - 4'd1;
         else begin
            d_s1 = 4'd5;
            if (m0 != 4'd0) d_m0 = m0 - 4'd1;
            else begin
               d_m0 = 4'd9;
               if (m1 != 4'd0) d_m1 = m1 - 4'd1;
               else begin
                  d_m1 = 4'd5;
                  if (h0 != 4'd0) d_h0 = h0 - 4'd1;
                  else begin
                     d_h0 = 4'd9;
                     d_h1 = h1 - 4'd1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {h1, h0, m1, m0, s1, s0} <= '0;
         running   <= 1'b0;
         expired   <= 1'b0;
         prescaler <= '0;
      end else if (clear) begin
         {h1, h0, m1, m0, s1, s0} <= '0;
         running   <= 1'b0;
         expired   <= 1'b0;
         prescaler <= '0;
      end else if (load) begin
         {h1, h0, m1, m0, s1, s0} <= {bcd_h, bcd_m, bcd_s};
         running   <= 1'b0;
         expired   <= 1'b0;
         prescaler <= '0;
      end else if (stop) begin
         running <= 1'b0;
      end else if (start && !running && !(down && is_zero)) begin
         running   <= 1'b1;
         expired   <= 1'b0;
         prescaler <= '0;
      end else if (running) begin
         if (tick) begin
            prescaler <= '0;
            if (down) begin
               // A countdown that hits (or sits at) zero stops and flags expiry.
               if (is_zero) begin
                  running <= 1'b0;
                  expired <= 1'b1;
               end else begin
                  {h1, h0, m1, m0, s1, s0} <= {d_h1, d_h0, d_m1, d_m0, d_s1, d_s0};
                  if (dn_zero) begin
                     running <= 1'b0;
                     expired <= 1'b1;
                  end
               end
            end else begin
               {h1, h0, m1, m0, s1, s0} <= {u_h1, u_h0, u_m1, u_m0, u_s1, u_s0};
            end
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == SCAN_MAX) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      case (3'(scan_idx))
         3'd1:    cur = s1;
         3'd2:    cur = m0;
         3'd3:    cur = m1;
         3'd4:    cur = h0;
         3'd5:    cur = h1;
         default: cur = s0;
      endcase
   end

   assign number      = seg(cur);
   assign digit_block = {{(DIGITS-1){1'b0}}, 1'b1} << scan_idx;

endmodule

// File: tb/tb_timer_mux_display.sv
// Drives three timer_mux_display instances (2, 4 and 6 digits) with shared stimulus
// and compares every output each cycle against a seconds-based reference model.
module tb_timer_mux_display;

   localparam int TD = 4;
   localparam int SD = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, clear = 1'b0, down = 1'b0, load = 1'b0;
   logic [4:0] load_h = '0;
   logic [5:0] load_m = '0, load_s = '0;

   logic [7:0] num2, num4, num6;
   logic [1:0] blk2;
   logic [3:0] blk4;
   logic [5:0] blk6;
   logic       exp2, exp4, exp6;

   int checks = 0;
   int errors = 0;

   // Reference state: count kept as total seconds, not as BCD digits.
   int cnt [3];
   int pre [3];
   bit run [3];
   bit ex  [3];
   int sidx[3];
   int scnt;
   int dig [3] = '{2, 4, 6};
   int modv[3] = '{60, 3600, 86400};

   always #5 clk = ~clk;

   timer_mux_display #(.DIGITS(2), .TICK_DIV(TD), .SCAN_DIV(SD)) d2 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .down(down),
      .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
      .number(num2), .digit_block(blk2), .expired(exp2));
   timer_mux_display #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD)) d4 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .down(down),
      .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
      .number(num4), .digit_block(blk4), .expired(exp4));
   timer_mux_display #(.DIGITS(6), .TICK_DIV(TD), .SCAN_DIV(SD)) d6 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .down(down),
      .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
      .number(num6), .digit_block(blk6), .expired(exp6));

   function automatic logic [7:0] seg_code(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  default: return 8'h90;
      endcase
   endfunction

   function automatic int digit_of(input int c, input int i);
      int s, m, h;
      s = c % 60;
      m = (c / 60) % 60;
      h = c / 3600;
      case (i)
         0: return s % 10;
         1: return s / 10;
         2: return m % 10;
         3: return m / 10;
         4: return h % 10;
         default: return h / 10;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      if (obs !== req) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, req);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         cnt[k] = 0; pre[k] = 0; run[k] = 0; ex[k] = 0; sidx[k] = 0;
      end
      scnt = 0;
   endtask

   task automatic model_update();
      int h, m, s;
      if (rst) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 3; k++) begin
         if (clear) begin
            cnt[k] = 0; run[k] = 0; ex[k] = 0; pre[k] = 0;
         end else if (load) begin
            h = (dig[k] == 6 && load_h < 24) ? int'(load_h) : 0;
            m = (dig[k] >= 4 && load_m < 60) ? int'(load_m) : 0;
            s = (load_s < 60) ? int'(load_s) : 0;
            cnt[k] = h * 3600 + m * 60 + s;
            run[k] = 0; ex[k] = 0; pre[k] = 0;
         end else if (stop) begin
            run[k] = 0;
         end else if (start && !run[k] && !(down && cnt[k] == 0)) begin
            run[k] = 1; ex[k] = 0; pre[k] = 0;
         end else if (run[k]) begin
            if (pre[k] == TD - 1) begin
               pre[k] = 0;
               if (down) begin
                  if (cnt[k] > 0) cnt[k] = cnt[k] - 1;
                  if (cnt[k] == 0) begin
                     run[k] = 0; ex[k] = 1;
                  end
               end else begin
                  cnt[k] = (cnt[k] + 1) % modv[k];
               end
            end else begin
               pre[k] = pre[k] + 1;
            end
         end
      end
      if (scnt == SD - 1) begin
         scnt = 0;
         for (int k = 0; k < 3; k++) sidx[k] = (sidx[k] + 1) % dig[k];
      end else begin
         scnt = scnt + 1;
      end
   endtask

   task automatic check_all();
      check_val("d2 digit_block", 32'(blk2), 32'(1 << sidx[0]));
      check_val("d2 number", 32'(num2), 32'(seg_code(digit_of(cnt[0], sidx[0]))));
      check_val("d2 expired", 32'(exp2), 32'(ex[0]));
      check_val("d4 digit_block", 32'(blk4), 32'(1 << sidx[1]));
      check_val("d4 number", 32'(num4), 32'(seg_code(digit_of(cnt[1], sidx[1]))));
      check_val("d4 expired", 32'(exp4), 32'(ex[1]));
      check_val("d6 digit_block", 32'(blk6), 32'(1 << sidx[2]));
      check_val("d6 number", 32'(num6), 32'(seg_code(digit_of(cnt[2], sidx[2]))));
      check_val("d6 expired", 32'(exp6), 32'(ex[2]));
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_update();
         @(negedge clk);
         check_all();
      end
   endtask

   task automatic idle();
      start = 0; stop = 0; clear = 0; load = 0;
   endtask

   task automatic do_load(input int h, input int m, input int s);
      idle();
      load_h = 5'(h); load_m = 6'(m); load_s = 6'(s);
      load = 1;
      step(1);
      load = 0;
   endtask

   task automatic pulse_start();
      idle();
      start = 1;
      step(1);
      start = 0;
   endtask

   task automatic rand_load();
      case ($urandom_range(0, 2))
         0: begin
            load_h = 5'($urandom_range(0, 25));
            load_m = 6'($urandom_range(0, 61));
            load_s = 6'($urandom_range(0, 61));
         end
         1: begin
            load_h = 5'd23; load_m = 6'd59; load_s = 6'($urandom_range(50, 59));
         end
         default: begin
            load_h = 5'd0; load_m = 6'($urandom_range(0, 1)); load_s = 6'($urandom_range(0, 5));
         end
      endcase
   endtask

   initial begin
      model_reset();
      // Reset held for three edges, then scan rotation with idle controls.
      rst = 1;
      step(3);
      @(negedge clk);
      rst = 0;
      check_all();
      step(14);

      // Count-up carry and full-day wrap.
      do_load(0, 0, 58);
      pulse_start();
      step(10);
      do_load(23, 59, 59);
      pulse_start();
      step(16);

      // Countdown to expiry, start at zero is ignored, clear drops expired.
      down = 1;
      do_load(0, 1, 1);
      pulse_start();
      step(4 * 62 + 6);
      pulse_start();
      step(6);
      idle(); clear = 1; step(1); clear = 0;
      step(2);

      // Stop with the prescaler part-way, then resume.
      down = 0;
      do_load(0, 0, 5);
      pulse_start();
      step(2);
      idle(); stop = 1; step(10); stop = 0;
      pulse_start();
      step(9);
      idle(); clear = 1; start = 1; step(1); idle();
      step(4);

      // Hours ignored by the short displays; MM:SS and SS wrap.
      do_load(7, 59, 59);
      pulse_start();
      step(9);

      // Out-of-range fields load as zero.
      do_load(25, 61, 30);
      step(3);

      // Asynchronous reset pulse between edges.
      pulse_start();
      step(5);
      #2;
      rst = 1;
      #1;
      model_reset();
      check_all();
      #1;
      rst = 0;
      step(4);

      // Randomized control traffic.
      for (int i = 0; i < 3000; i++) begin
         int r;
         idle();
         r = $urandom_range(0, 99);
         if (r < 2) clear = 1;
         else if (r < 7) begin
            load = 1;
            rand_load();
         end
         else if (r < 11) stop = 1;
         else if (r < 30) start = 1;
         if ($urandom_range(0, 99) < 3) down = ~down;
         step(1);
      end
      idle();
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
